// File: rtl/sha256_sched_ctrl_if.sv
// Handshake and datapath bundle between the SHA-256 schedule sequencer,
// the message buffer, the expansion shift register and the round core.
// The sequencer connects through the slave modport; the surrounding
// environment (buffer, expansion unit, round core) uses the master modport.
interface sha256_sched_ctrl_if #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 6
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              msg_valid;
    logic              msg_ready;
    logic [WORD_W-1:0] msg_word;
    logic [WORD_W-1:0] exp_in;
    logic              exp_sel;
    logic              exp_en;
    logic [WORD_W-1:0] exp_out;
    logic              round_valid;
    logic              round_ready;
    logic [WORD_W-1:0] round_w;
    logic [WORD_W-1:0] round_k;
    logic [IDX_W-1:0]  round_idx;
    logic              last_round;

    modport master (
        output start, abort, msg_valid, msg_word, exp_out, round_ready,
        input  busy, done, msg_ready, exp_in, exp_sel, exp_en,
               round_valid, round_w, round_k, round_idx, last_round
    );

    modport slave (
        input  start, abort, msg_valid, msg_word, exp_out, round_ready,
        output busy, done, msg_ready, exp_in, exp_sel, exp_en,
               round_valid, round_w, round_k, round_idx, last_round
    );
endinterface

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 message-schedule sequencer. Loads 16 message words into the
// expansion shift register, then steps it 48 times, presenting W_t, K_t and
// t to the compression core. Message and round handshakes are passed through
// combinationally so there is no word buffer and no added latency; the
// expansion register only shifts on an accepted round.
module sha256_sched_ctrl #(
    parameter int WORD_W     = 32,
    parameter int LOAD_WORDS = 16,
    parameter int ROUNDS     = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    sha256_sched_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(ROUNDS);
    localparam logic [IDX_W-1:0] LAST_LOAD_IDX  = IDX_W'(LOAD_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_ROUND_IDX = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE        = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO       = IDX_W'(0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_EXPAND = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Round constants K_0..K_63 (first 32 bits of the fractional parts of
    // the cube roots of the first 64 primes).
    function automatic logic [WORD_W-1:0] k_rom(input logic [IDX_W-1:0] idx);
        case (idx)
            6'd0:  k_rom = 32'h428a2f98;  6'd1:  k_rom = 32'h71374491;
            6'd2:  k_rom = 32'hb5c0fbcf;  6'd3:  k_rom = 32'he9b5dba5;
            6'd4:  k_rom = 32'h3956c25b;  6'd5:  k_rom = 32'h59f111f1;
            6'd6:  k_rom = 32'h923f82a4;  6'd7:  k_rom = 32'hab1c5ed5;
            6'd8:  k_rom = 32'hd807aa98;  6'd9:  k_rom = 32'h12835b01;
            6'd10: k_rom = 32'h243185be;  6'd11: k_rom = 32'h550c7dc3;
            6'd12: k_rom = 32'h72be5d74;  6'd13: k_rom = 32'h80deb1fe;
            6'd14: k_rom = 32'h9bdc06a7;  6'd15: k_rom = 32'hc19bf174;
            6'd16: k_rom = 32'he49b69c1;  6'd17: k_rom = 32'hefbe4786;
            6'd18: k_rom = 32'h0fc19dc6;  6'd19: k_rom = 32'h240ca1cc;
            6'd20: k_rom = 32'h2de92c6f;  6'd21: k_rom = 32'h4a7484aa;
            6'd22: k_rom = 32'h5cb0a9dc;  6'd23: k_rom = 32'h76f988da;
            6'd24: k_rom = 32'h983e5152;  6'd25: k_rom = 32'ha831c66d;
            6'd26: k_rom = 32'hb00327c8;  6'd27: k_rom = 32'hbf597fc7;
            6'd28: k_rom = 32'hc6e00bf3;  6'd29: k_rom = 32'hd5a79147;
            6'd30: k_rom = 32'h06ca6351;  6'd31: k_rom = 32'h14292967;
            6'd32: k_rom = 32'h27b70a85;  6'd33: k_rom = 32'h2e1b2138;
            6'd34: k_rom = 32'h4d2c6dfc;  6'd35: k_rom = 32'h53380d13;
            6'd36: k_rom = 32'h650a7354;  6'd37: k_rom = 32'h766a0abb;
            6'd38: k_rom = 32'h81c2c92e;  6'd39: k_rom = 32'h92722c85;
            6'd40: k_rom = 32'ha2bfe8a1;  6'd41: k_rom = 32'ha81a664b;
            6'd42: k_rom = 32'hc24b8b70;  6'd43: k_rom = 32'hc76c51a3;
            6'd44: k_rom = 32'hd192e819;  6'd45: k_rom = 32'hd6990624;
            6'd46: k_rom = 32'hf40e3585;  6'd47: k_rom = 32'h106aa070;
            6'd48: k_rom = 32'h19a4c116;  6'd49: k_rom = 32'h1e376c08;
            6'd50: k_rom = 32'h2748774c;  6'd51: k_rom = 32'h34b0bcb5;
            6'd52: k_rom = 32'h391c0cb3;  6'd53: k_rom = 32'h4ed8aa4a;
            6'd54: k_rom = 32'h5b9cca4f;  6'd55: k_rom = 32'h682e6ff3;
            6'd56: k_rom = 32'h748f82ee;  6'd57: k_rom = 32'h78a5636f;
            6'd58: k_rom = 32'h84c87814;  6'd59: k_rom = 32'h8cc70208;
            6'd60: k_rom = 32'h90befffa;  6'd61: k_rom = 32'ha4506ceb;
            6'd62: k_rom = 32'hbef9a3f7;  6'd63: k_rom = 32'hc67178f2;
            default: k_rom = 32'h00000000;
        endcase
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic [IDX_W-1:0] t_r;
    logic [IDX_W-1:0] next_t_s;
    logic             busy_r;
    logic             done_r;
    logic             exp_sel_r;
    logic             msg_ready_s;
    logic             round_valid_s;
    logic             exp_en_s;

    // Next-state, round counter and pass-through handshake decode; abort wins over any transfer.
    always_comb begin
        next_state_s  = state_r;
        next_t_s      = t_r;
        msg_ready_s   = 1'b0;
        round_valid_s = 1'b0;
        exp_en_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                next_t_s = IDX_ZERO;
                if (bus.start) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    next_state_s = ST_IDLE;
                    next_t_s     = IDX_ZERO;
                end else begin
                    round_valid_s = bus.msg_valid;
                    msg_ready_s   = bus.round_ready;
                    if (bus.msg_valid && bus.round_ready) begin
                        exp_en_s = 1'b1;
                        next_t_s = t_r + IDX_ONE;
                        if (t_r == LAST_LOAD_IDX) begin
                            next_state_s = ST_EXPAND;
                        end else begin
                            next_state_s = ST_LOAD;
                        end
                    end else begin
                        exp_en_s = 1'b0;
                    end
                end
            end
            ST_EXPAND: begin
                if (bus.abort) begin
                    next_state_s = ST_IDLE;
                    next_t_s     = IDX_ZERO;
                end else begin
                    round_valid_s = 1'b1;
                    exp_en_s      = bus.round_ready;
                    if (bus.round_ready) begin
                        // t holds at the last index into DONE rather than wrapping.
                        if (t_r == LAST_ROUND_IDX) begin
                            next_state_s = ST_DONE;
                        end else begin
                            next_t_s = t_r + IDX_ONE;
                        end
                    end else begin
                        next_t_s = t_r;
                    end
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
                next_t_s     = IDX_ZERO;
            end
            default: begin
                next_state_s = ST_IDLE;
                next_t_s     = IDX_ZERO;
            end
        endcase
    end

    // State, round counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            t_r       <= IDX_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            exp_sel_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            t_r       <= next_t_s;
            busy_r    <= (next_state_s != ST_IDLE);
            done_r    <= (next_state_s == ST_DONE);
            exp_sel_r <= (next_state_s == ST_EXPAND);
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.exp_sel     = exp_sel_r;
    assign bus.exp_en      = exp_en_s;
    assign bus.exp_in      = bus.msg_word;
    assign bus.msg_ready   = msg_ready_s;
    assign bus.round_valid = round_valid_s;
    assign bus.round_w     = bus.exp_out;
    assign bus.round_k     = k_rom(t_r);
    assign bus.round_idx   = t_r;
    assign bus.last_round  = round_valid_s && (t_r == LAST_ROUND_IDX);
endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Directed bench for sha256_sched_ctrl: a behavioural expansion shift
// register closes the loop, the padded "abc" block is streamed, and control
// outputs, round index, W_t and selected K_t are checked every cycle.
module tb_sha256_sched_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha256_sched_ctrl_if bus ();
    sha256_sched_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] blk   [0:15];
    logic [31:0] w_ref [0:63];
    logic [31:0] win   [0:15];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Behavioural expansion unit: win[0] is W_{t-16}, win[15] is W_{t-1}.
    assign bus.exp_out = bus.exp_sel ? (ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0])
                                     : bus.exp_in;
    always @(posedge clk) begin
        if (bus.exp_en) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= bus.exp_out;
        end
    end

    function automatic logic [6:0] ctrl_vec();
        return {bus.busy, bus.done, bus.round_valid, bus.msg_ready,
                bus.exp_en, bus.exp_sel, bus.last_round};
    endfunction

    // Hand-computed W values for the "abc" block; other indices use the reference schedule.
    function automatic logic [31:0] w_expect(input int i);
        case (i)
            0:  return 32'h61626380;
            15: return 32'h00000018;
            16: return 32'h61626380;
            17: return 32'h000f0000;
            18: return 32'h7da86405;
            19: return 32'h600003c6;
            default: return w_ref[i];
        endcase
    endfunction

    function automatic logic [31:0] k_hand(input int i);
        case (i)
            0:  return 32'h428a2f98;
            5:  return 32'h59f111f1;
            20: return 32'h2de92c6f;
            40: return 32'ha2bfe8a1;
            63: return 32'hc67178f2;
            default: return 32'h00000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // One block from the IDLE start cycle back to IDLE; -1 disables a feature.
    task automatic run_block(input string nm, input int stall_a, input int stall_b,
                             input bit gaps, input int abort_at, input int rst_at,
                             input bit pulse_start, input int exp_cycles);
        int t_exp, phase, stall_left, gap_left, cycles, dut_dones;
        bit sa_used, sb_used, xfer, ab, rr, mv, rv, hit_rst;
        logic [6:0] ev;
        t_exp = 0; phase = 1; stall_left = 0; gap_left = 0; cycles = 0; dut_dones = 0;
        sa_used = 1'b0; sb_used = 1'b0; hit_rst = 1'b0;
        bus.start = 1'b1; bus.abort = 1'b0; bus.msg_valid = 1'b0; bus.round_ready = 1'b1;
        bus.msg_word = 32'h0;
        #1;
        chk({nm, ":start_idle"}, 32'(ctrl_vec()), 32'h0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (phase != 0 && cycles < 200) begin
            if (t_exp == stall_a && !sa_used && phase != 3) begin stall_left = 3; sa_used = 1'b1; end
            if (t_exp == stall_b && !sb_used && phase != 3) begin stall_left = 3; sb_used = 1'b1; end
            rr = (stall_left == 0);
            mv = (phase == 1) && (gap_left == 0);
            ab = (phase == 2) && (t_exp == abort_at);
            bus.round_ready = rr;
            bus.msg_valid   = mv;
            bus.abort       = ab;
            bus.msg_word    = (phase == 1) ? blk[t_exp % 16] : 32'hdeadbeef;
            bus.start       = pulse_start && ((phase == 1 && t_exp == 10) || phase == 3);
            if (phase == 2 && t_exp == rst_at) begin
                bus.start = 1'b0;
                rst_n = 1'b0;
                #1;
                chk({nm, ":rst_ctrl"}, 32'(ctrl_vec()), 32'h0);
                chk({nm, ":rst_idx"}, 32'(bus.round_idx), 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                hit_rst = 1'b1;
                phase = 0;
            end else begin
                #1;
                xfer = (phase == 1) ? (mv && rr && !ab) : ((phase == 2) ? (rr && !ab) : 1'b0);
                rv   = (phase == 1) ? (mv && !ab) : ((phase == 2) ? !ab : 1'b0);
                ev   = {1'b1, phase == 3, rv, (phase == 1) && rr && !ab, xfer,
                        phase == 2, (phase == 2) && !ab && (t_exp == 63)};
                chk({nm, ":ctrl"}, 32'(ctrl_vec()), 32'(ev));
                if (phase != 3) chk({nm, ":idx"}, 32'(bus.round_idx), 32'(t_exp));
                if (rv) chk({nm, ":w"}, bus.round_w, w_expect(t_exp));
                if (rv && k_hand(t_exp) != 32'h0) chk({nm, ":k"}, bus.round_k, k_hand(t_exp));
                dut_dones += int'(bus.done);
                @(posedge clk); #1;
                cycles++;
                if (stall_left > 0) stall_left--;
                if (gap_left > 0) gap_left--;
                if (gaps && phase == 1 && xfer && ((t_exp + 1) % 4 == 0) && (t_exp + 1 < 16))
                    gap_left = 2;
                if (ab) phase = 0;
                else if (phase == 3) phase = 0;
                else if (xfer) begin
                    if (phase == 2 && t_exp == 63) phase = 3;
                    else begin
                        t_exp++;
                        if (t_exp == 16) phase = 2;
                    end
                end
            end
        end
        chk({nm, ":finished"}, 32'(phase), 32'h0);
        bus.start = 1'b0; bus.abort = 1'b0; bus.msg_valid = 1'b0; bus.round_ready = 1'b1;
        #1;
        chk({nm, ":end_idle"}, 32'(ctrl_vec()), 32'h0);
        chk({nm, ":end_idx"}, 32'(bus.round_idx), 32'h0);
        chk({nm, ":dones"}, 32'(dut_dones), (abort_at >= 0 || hit_rst) ? 32'd0 : 32'd1);
        if (exp_cycles >= 0) chk({nm, ":cycles"}, 32'(cycles), 32'(exp_cycles));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        for (int i = 0; i < 16; i++) w_ref[i] = blk[i];
        for (int i = 16; i < 64; i++)
            w_ref[i] = ssig1(w_ref[i-2]) + w_ref[i-7] + ssig0(w_ref[i-15]) + w_ref[i-16];

        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.msg_valid = 1'b0;
        bus.round_ready = 1'b0; bus.msg_word = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'(ctrl_vec()), 32'h0);
        chk("reset_idx", 32'(bus.round_idx), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 65 cycles after the start cycle: 64 transfers plus DONE.
        run_block("T2",    -1, -1, 1'b0, -1, -1, 1'b0, 65);
        run_block("T3",     5, 40, 1'b0, -1, -1, 1'b0, 71);
        run_block("T4",    -1, -1, 1'b1, -1, -1, 1'b0, 71);
        run_block("T5",    -1, -1, 1'b0, 20, -1, 1'b0, 21);
        run_block("T5_re", -1, -1, 1'b0, -1, -1, 1'b0, 65);
        run_block("T6",    -1, -1, 1'b0, -1, -1, 1'b1, 65);
        run_block("T6_re", -1, -1, 1'b0, -1, -1, 1'b0, 65);
        run_block("T1",    -1, -1, 1'b0, -1, 30, 1'b0, -1);
        run_block("T1_re", -1, -1, 1'b0, -1, -1, 1'b0, 65);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
